div_iter: RTL and testbench
===========================

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter DW, default 32, the operand width; all concrete values below use DW=32.
REQ-002 SHALL have port clk  input  1  the single clock; all state SHALL change on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned divide.
REQ-005 SHALL have port opdata1_i  input  DW  dividend.
REQ-006 SHALL have port opdata2_i  input  DW  divisor.
REQ-007 SHALL have port start_i  input  1  1 (DivStart) = request a divide, 0 (DivStop) = no request or release of a finished result.
REQ-008 SHALL have port annul_i  input  1  abort the operation in progress.
REQ-009 SHALL have port result_o  output  2*DW  {remainder[2DW-1:DW], quotient[DW-1:0]}, registered.
REQ-010 SHALL have port ready_o  output  1  1 (DivResultReady) = result_o valid, registered.

Function
REQ-011 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-012 In FREE, with start_i=1 and annul_i=0, SHALL latch the operands and signed_div_i; next state BYZERO if divisor==0, else ON; iteration counter cleared to 0.
REQ-013 In FREE, with start_i=0 or annul_i=1, SHALL remain in FREE with ready_o=0 and result_o=0.
REQ-014 When latching a signed operation, SHALL store the magnitude of each negative operand (0-x mod 2^DW); operands SHALL be stored unchanged when unsigned.
REQ-015 After the latch, SHALL ignore changes on opdata1_i, opdata2_i and signed_div_i until the next return to FREE.
REQ-016 In ON, SHALL perform one restoring shift-subtract step per cycle on a 2DW+1-bit working register, with exactly DW steps per operation; the counter runs 0..DW-1.
REQ-017 After step DW-1, SHALL go to END, load result_o and set ready_o=1 on that same edge.
REQ-018 Latency: SHALL assert ready_o exactly DW+1 = 33 rising edges after the edge that sampled start_i in FREE.
REQ-019 In BYZERO, SHALL go to END on the next edge with result_o=0 and ready_o=1, i.e. 2 edges after the start sample.
REQ-020 Signed quotient SHALL be negated when the operand signs differ; signed remainder SHALL take the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL wrap: quotient 0x80000000, remainder 0, with no flag.
REQ-022 In END, SHALL hold ready_o=1 and result_o stable while start_i=1.
REQ-023 In END, when start_i=0, SHALL go to FREE on the next edge with ready_o=0 and result_o=0.
REQ-024 A fresh divide SHALL require at least one FREE cycle; start_i held high through END SHALL NOT restart the operation.
REQ-025 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge with ready_o=0 and result_o=0; ready_o SHALL never rise for an annulled operation.
REQ-026 annul_i SHALL be ignored in END.
REQ-027 A start_i drop while in ON SHALL NOT abort the operation; only annul_i or rst abort.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state FREE, counter 0, working register 0, result_o=0 and ready_o=0.
REQ-029 Assertion of rst in any state, including mid-ON, SHALL discard the operation; after release the block SHALL accept a start in the first FREE cycle.

Verification
REQ-030 SHALL cover: unsigned 100/7, start held -> ready_o=1 on edge 33, result_o={0x00000002, 0x0000000E}; drop start_i -> ready_o=0 and result_o=0 next edge.
REQ-031 SHALL cover: signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-032 SHALL cover: signed 0x80000000/0xFFFFFFFF -> result_o={0x00000000, 0x80000000}, ready_o on edge 33.
REQ-033 SHALL cover: divisor 0 -> ready_o=1 on edge 2 with result_o=0; unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-034 SHALL cover: annul_i pulsed at iteration 10 -> FREE next edge, ready_o stays 0; an immediate new 100/7 still completes correctly on edge 33.
REQ-035 SHALL cover: rst asserted asynchronously at iteration 20 -> ready_o and result_o go 0 before the next clk edge; opdata changes during ON do not alter the result.

Source files
------------

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Iterative restoring divider, signed or unsigned, one quotient
//            bit per clock. Returns {remainder, quotient} with a ready flag
//            that stays up until the requester releases start_i.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1       rising-edge clock
//   rst           in   1       asynchronous active-high reset
//   signed_div_i  in   1       1 = two's-complement divide, 0 = unsigned
//   opdata1_i     in   DW      dividend
//   opdata2_i     in   DW      divisor
//   start_i       in   1       1 = request a divide / hold result,
//                              0 = no request / release finished result
//   annul_i       in   1       abort the operation in progress
//   result_o      out  2*DW    {remainder, quotient}, registered
//   ready_o       out  1       result_o valid, registered
// ============================================================================
module div_iter #(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_div_i,
  input  logic [DW-1:0]     opdata1_i,
  input  logic [DW-1:0]     opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  output logic [2*DW-1:0]   result_o,
  output logic              ready_o
);

  localparam int            c_CW   = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DW - 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  // Registered state
  state_t            r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [2*DW:0]     r_work;     // {partial remainder (DW+1), dividend/quotient (DW)}
  logic [DW-1:0]     r_divisor;  // divisor magnitude
  logic              r_neg_q;    // quotient must be negated at the end
  logic              r_neg_r;    // remainder must be negated at the end

  // Next-state values
  state_t            w_state_nxt;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic [2*DW:0]     w_work_nxt;
  logic [DW-1:0]     w_divisor_nxt;
  logic              w_neg_q_nxt;
  logic              w_neg_r_nxt;
  logic [2*DW-1:0]   w_result_nxt;
  logic              w_ready_nxt;

  // Operand magnitudes for the latch cycle
  logic              w_op1_neg;
  logic              w_op2_neg;
  logic [DW-1:0]     w_op1_mag;
  logic [DW-1:0]     w_op2_mag;

  // One restoring step
  logic [2*DW:0]     w_shift;
  logic [DW:0]       w_diff;
  logic              w_fits;
  logic [2*DW:0]     w_step;
  logic [DW-1:0]     w_quot;
  logic [DW-1:0]     w_rem;
  logic [DW-1:0]     w_quot_fix;
  logic [DW-1:0]     w_rem_fix;

  assign w_op1_neg = signed_div_i & opdata1_i[DW-1];
  assign w_op2_neg = signed_div_i & opdata2_i[DW-1];
  assign w_op1_mag = w_op1_neg ? (DW'(0) - opdata1_i) : opdata1_i;
  assign w_op2_mag = w_op2_neg ? (DW'(0) - opdata2_i) : opdata2_i;

  // Shift the working register left, then try to subtract the divisor from
  // the upper DW+1 bits. The partial remainder is always below the divisor,
  // so after the shift it fits in DW+1 bits and the borrow shows up as the
  // top bit of the difference.
  assign w_shift = r_work << 1;
  assign w_diff  = w_shift[2*DW:DW] - {1'b0, r_divisor};
  assign w_fits  = ~w_diff[DW];
  assign w_step  = w_fits ? {w_diff, w_shift[DW-1:1], 1'b1} : w_shift;

  // Quotient bits accumulate in the low half, remainder in the high half.
  assign w_quot = w_step[DW-1:0];
  assign w_rem  = w_step[2*DW-1:DW];

  // Sign restoration. The most-negative / -1 case wraps naturally to the
  // most-negative value, so no overflow handling is needed.
  assign w_quot_fix = r_neg_q ? (DW'(0) - w_quot) : w_quot;
  assign w_rem_fix  = r_neg_r ? (DW'(0) - w_rem)  : w_rem;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      result_o  <= w_result_nxt;
      ready_o   <= w_ready_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_result_nxt  = result_o;
    w_ready_nxt   = ready_o;

    case (r_state)
      S_FREE: begin
        w_result_nxt = '0;
        w_ready_nxt  = 1'b0;
        if (start_i && !annul_i) begin
          // Operands and sign mode are captured here only; later input
          // changes have no effect until the block returns to FREE.
          w_work_nxt    = {{(DW+1){1'b0}}, w_op1_mag};
          w_divisor_nxt = w_op2_mag;
          w_neg_q_nxt   = w_op1_neg ^ w_op2_neg;
          w_neg_r_nxt   = w_op1_neg;
          w_cnt_nxt     = '0;
          w_state_nxt   = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          w_state_nxt  = S_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end else begin
          w_state_nxt  = S_END;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b1;
        end
      end

      S_ON: begin
        // Dropping start_i here does not abort; only annul_i or rst do.
        if (annul_i) begin
          w_state_nxt  = S_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end else begin
          w_work_nxt = w_step;
          if (r_cnt == c_LAST) begin
            // Final step: publish the sign-corrected result on the same edge.
            w_state_nxt  = S_END;
            w_result_nxt = {w_rem_fix, w_quot_fix};
            w_ready_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + c_CW'(1);
          end
        end
      end

      S_END: begin
        // annul_i is ignored here; the result is held until start_i drops,
        // so a start held high cannot re-trigger without a FREE cycle.
        if (!start_i) begin
          w_state_nxt  = S_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt  = S_FREE;
        w_result_nxt = '0;
        w_ready_nxt  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : Self-checking bench for div_iter: a table of directed divides
//            plus hand-written annul, start-drop and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total;
  int bad;

  div_iter #(.DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t tv[11];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Start a divide, find the edge (counting the start-sampling edge as 1) on
  // which ready_o rises, check the result, hold start while scrambling the
  // inputs and pulsing annul, then release and check the clear.
  task automatic run_div(input int id, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q,
                         input logic [31:0] r, input int lat);
    int e;
    logic [63:0] first;
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        e = k;
        break;
      end
    end
    check($sformatf("v%0d latency", id), 64'(e), 64'(lat));
    check($sformatf("v%0d result", id), result_o, {r, q});
    first = result_o;
    @(negedge clk);
    opdata1_i    = ~a;
    opdata2_i    = 32'd3;
    signed_div_i = ~sg;
    annul_i      = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check($sformatf("v%0d hold ready", id), 64'(ready_o), 64'd1);
    check($sformatf("v%0d hold result", id), result_o, first);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d release ready", id), 64'(ready_o), 64'd0);
    check($sformatf("v%0d release result", id), result_o, 64'd0);
  endtask

  initial begin
    int e;
    logic seen;

    total = 0;
    bad   = 0;

    tv[0]  = '{1'b0, 32'd100,        32'd7,        32'h0000000E, 32'h00000002, 33};
    tv[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    tv[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33};
    tv[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33};
    tv[4]  = '{1'b0, 32'h00001234,   32'h00000000, 32'h00000000, 32'h00000000, 2};
    tv[5]  = '{1'b0, 32'hFFFFFFFF,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 33};
    tv[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    tv[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 33};
    tv[8]  = '{1'b0, 32'hFFFFFFFF,   32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 33};
    tv[9]  = '{1'b1, 32'h00000000,   32'h00000005, 32'h00000000, 32'h00000000, 33};
    tv[10] = '{1'b1, 32'hFFFFFFFB,   32'h00000000, 32'h00000000, 32'h00000000, 2};

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    #22;
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_div(i, tv[i].sg, tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].lat);

    // Annul during iteration 10, then an immediate fresh divide.
    seen = 1'b0;
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready_o) seen = 1'b1;
    end
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    if (ready_o) seen = 1'b1;
    check("annul ready", 64'(ready_o), 64'd0);
    check("annul result", result_o, 64'd0);
    check("annul never ready", 64'(seen), 64'd0);
    annul_i = 1'b0;
    run_div(100, 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 33);

    // start_i dropped and operands scrambled during ON: operation continues
    // with the latched values and clears the cycle after END.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd10;
    start_i      = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start_i      = 1'b0;
    opdata1_i    = 32'hDEADBEEF;
    opdata2_i    = 32'h0;
    signed_div_i = 1'b1;
    e = 0;
    for (int k = 2; k <= 60; k++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        e = k;
        break;
      end
    end
    check("drop latency", 64'(e), 64'd33);
    check("drop result", result_o, {32'd0, 32'd100});
    @(posedge clk); #1;
    check("drop clear ready", 64'(ready_o), 64'd0);
    check("drop clear result", result_o, 64'd0);

    // Asynchronous reset at iteration 20, then immediate restart.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk); #1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst mid ready", 64'(ready_o), 64'd0);
    check("rst mid result", result_o, 64'd0);
    start_i = 1'b0;
    #3;
    rst = 1'b0;
    run_div(101, 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 33);

    // Asynchronous reset while a result is being held in END.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd6;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    e = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        e = k;
        break;
      end
    end
    check("end latency", 64'(e), 64'd33);
    check("end result", result_o, {32'd0, 32'd2});
    #2;
    rst = 1'b1;
    #1;
    check("rst end ready", 64'(ready_o), 64'd0);
    check("rst end result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b0;
    run_div(102, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
